// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: turns validated set-2 scan-code bytes into key events
// ({ext, brk, code}) held in a first-word-fall-through FIFO drained by valid/ready.
// Optional macro PS2_KBD_TYPEMATIC_FILTER_EN suppresses auto-repeat make events.
module ps2_kbd_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AW         = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [7:0]    evt_code,
    output logic          evt_ext,
    output logic          evt_break,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    input  logic          clr_overflow
);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e state_q, state_d;

    // Decoder result for the current byte
    logic       dec_emit;
    logic       dec_ext;
    logic       dec_brk;
    logic       push_req;

    logic [9:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full;
    logic          pop;
    logic          push;

    // Prefix decoder next-state and emit decision
    always_comb begin
        state_d  = state_q;
        dec_emit = 1'b0;
        dec_ext  = 1'b0;
        dec_brk  = 1'b0;
        if (rx_valid) begin
            if (rx_data == 8'h00 || rx_data == 8'hFF) begin
                // Keyboard error/overrun codes abandon any partial sequence
                state_d = StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (rx_data == 8'hE0) begin
                            state_d = StExt;
                        end else if (rx_data == 8'hF0) begin
                            state_d = StBrk;
                        end else begin
                            dec_emit = 1'b1;
                        end
                    end
                    StExt: begin
                        if (rx_data == 8'hF0) begin
                            state_d = StExtBrk;
                        end else if (rx_data != 8'hE0) begin
                            dec_emit = 1'b1;
                            dec_ext  = 1'b1;
                            state_d  = StIdle;
                        end
                    end
                    StBrk: begin
                        if (rx_data == 8'hE0) begin
                            state_d = StExtBrk;
                        end else if (rx_data != 8'hF0) begin
                            dec_emit = 1'b1;
                            dec_brk  = 1'b1;
                            state_d  = StIdle;
                        end
                    end
                    StExtBrk: begin
                        if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
                            dec_emit = 1'b1;
                            dec_ext  = 1'b1;
                            dec_brk  = 1'b1;
                            state_d  = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // Decoder state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
    logic       held_valid_q, held_valid_d;
    logic       held_ext_q, held_ext_d;
    logic [7:0] held_code_q, held_code_d;
    logic       held_match;

    // Held-key tracking: repeated makes of the held key are swallowed
    always_comb begin
        held_valid_d = held_valid_q;
        held_ext_d   = held_ext_q;
        held_code_d  = held_code_q;
        held_match   = held_valid_q && (held_ext_q == dec_ext) && (held_code_q == rx_data);
        push_req     = dec_emit;
        if (dec_emit) begin
            if (!dec_brk) begin
                if (held_match) begin
                    push_req = 1'b0;
                end else begin
                    held_valid_d = 1'b1;
                    held_ext_d   = dec_ext;
                    held_code_d  = rx_data;
                end
            end else if (held_match) begin
                held_valid_d = 1'b0;
            end
        end
    end

    // Held-key register; updates even when the push itself is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            held_valid_q <= 1'b0;
            held_ext_q   <= 1'b0;
            held_code_q  <= 8'h00;
        end else begin
            held_valid_q <= held_valid_d;
            held_ext_q   <= held_ext_d;
            held_code_q  <= held_code_d;
        end
    end
`else
    // Every decoded event is queued
    always_comb begin
        push_req = dec_emit;
    end
`endif

    assign full = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop  = evt_valid & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push = push_req & (~full | pop);

    // FIFO pointer, count and overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        // Set wins over a simultaneous clear
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {dec_ext, dec_brk, rx_data};
        end
    end

    // Outputs come straight from registered state
    always_comb begin
        evt_valid  = (count_q != '0);
        fifo_count = count_q;
        overflow   = overflow_q;
        {evt_ext, evt_break, evt_code} = mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: stimulus pushes expected events, a monitor
// checks each popped head against the queue.
module tb_ps2_kbd_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       clr_overflow;

    int total;
    int bad;
    logic [9:0] exp_q[$];

    ps2_kbd_ctrl #(.FIFO_DEPTH(8), .AW(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_break    (evt_break),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: a pop happens at the next rising edge when valid & ready
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %h (ext,brk,code) required none",
                         {evt_ext, evt_break, evt_code});
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({evt_ext, evt_break, evt_code} !== e) begin
                    bad++;
                    $display("FAIL pop_event: got %h required %h",
                             {evt_ext, evt_break, evt_code}, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
        exp_q.push_back({ext, brk, code});
    endtask

    // Called at posedge+1; byte is sampled by the next rising edge
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        evt_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && fifo_count == 4'd0) begin
                done = 1'b1;
                break;
            end
        end
        evt_ready = 1'b0;
        check({name, "_drained"}, {31'd0, done}, 32'd1);
        check({name, "_valid_low"}, {31'd0, evt_valid}, 32'd0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_count", {28'd0, fifo_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);

        // Plain make code, one-cycle latency
        expect_evt(1'b0, 1'b0, 8'h1C);
        send(8'h1C);
        check("make_valid", {31'd0, evt_valid}, 32'd1);
        check("make_count", {28'd0, fifo_count}, 32'd1);
        drain("make");

        // Extended break
        expect_evt(1'b1, 1'b1, 8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("extbrk_count", {28'd0, fifo_count}, 32'd1);
        drain("extbrk");

        // Reset mid-prefix discards the E0
        send(8'hE0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_evt(1'b0, 1'b0, 8'h1C);
        send(8'h1C);
        check("rstmid_count", {28'd0, fifo_count}, 32'd1);
        drain("rstmid");

        // Prefix corner cases: repeated E0, F0-then-E0, error byte mid-sequence
        expect_evt(1'b1, 1'b0, 8'h14);
        send(8'hE0); send(8'hE0); send(8'h14);
        expect_evt(1'b1, 1'b1, 8'h12);
        send(8'hF0); send(8'hE0); send(8'h12);
        expect_evt(1'b0, 1'b0, 8'h12);
        send(8'hE0); send(8'h00); send(8'h12);
        expect_evt(1'b0, 1'b1, 8'h33);
        send(8'hF0); send(8'hF0); send(8'hFF); send(8'hF0); send(8'h33);
        check("corner_count", {28'd0, fifo_count}, 32'd4);
        drain("corner");

        // Overflow: nine makes into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) expect_evt(1'b0, 1'b0, 8'(i));
            send(8'(i));
        end
        check("ovf_count", {28'd0, fifo_count}, 32'd8);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_overflow = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO: emit and pop in the same cycle
        expect_evt(1'b0, 1'b0, 8'h0A);
        rx_data   = 8'h0A;
        rx_valid  = 1'b1;
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        evt_ready = 1'b0;
        check("fullpp_count", {28'd0, fifo_count}, 32'd8);
        check("fullpp_overflow", {31'd0, overflow}, 32'd0);
        drain("fullpp");

        // Typematic repeat
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
        expect_evt(1'b0, 1'b0, 8'h1C);
        expect_evt(1'b0, 1'b1, 8'h1C);
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        check("typematic_count", {28'd0, fifo_count}, 32'd2);
`else
        expect_evt(1'b0, 1'b0, 8'h1C);
        expect_evt(1'b0, 1'b0, 8'h1C);
        expect_evt(1'b0, 1'b0, 8'h1C);
        expect_evt(1'b0, 1'b1, 8'h1C);
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        check("typematic_count", {28'd0, fifo_count}, 32'd4);
`endif
        drain("typematic");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
